// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline boundary registers: payload widths,
// the nop encoding and the stall-mode selectors used by pipe_stage_reg.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Payload widths of the four classic boundaries
    localparam int IFID_W  = 64;
    localparam int IDEX_W  = 148;
    localparam int EXMEM_W = 107;
    localparam int MEMWB_W = 71;

    localparam int STALL_HOLD   = 0;
    localparam int STALL_BUBBLE = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-boundary register with stall, flush and legacy-bubble stall.
// Build option: define PIPE_STAGE_PERF_EN to add stall/flush event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] BUBBLE      = '0,
    parameter int               STALL_MODE  = STALL_HOLD,
    parameter int               BUBBLE_HI_W = 32,
    parameter int               CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             bubble_out
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    input  logic             cnt_clr
`endif
);

    logic [WIDTH-1:0] data_reg,   data_next;
    logic             valid_reg,  valid_next;
    logic             bubble_reg, bubble_next;
    logic [WIDTH-1:0] stall_data;

    // Payload seen on a legacy stall: upper field replaced, lower field kept
    generate
        if (BUBBLE_HI_W >= WIDTH) begin : g_hi_full
            assign stall_data = BUBBLE;
        end else if (BUBBLE_HI_W <= 0) begin : g_hi_none
            assign stall_data = data_reg;
        end else begin : g_hi_part
            assign stall_data = {BUBBLE[WIDTH-1 -: BUBBLE_HI_W],
                                 data_reg[WIDTH-BUBBLE_HI_W-1:0]};
        end
    endgenerate

    always_comb begin
        data_next   = data_reg;
        valid_next  = valid_reg;
        bubble_next = bubble_reg;
        if (flush) begin
            data_next   = BUBBLE;
            valid_next  = 1'b0;
            bubble_next = 1'b1;
        end else if (stall) begin
            if (STALL_MODE == STALL_BUBBLE) begin
                data_next   = stall_data;
                valid_next  = 1'b0;
                bubble_next = 1'b1;
            end
        end else begin
            data_next   = data_in;
            valid_next  = valid_in;
            bubble_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_reg   <= BUBBLE;
            valid_reg  <= 1'b0;
            bubble_reg <= 1'b0;
        end else begin
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            bubble_reg <= bubble_next;
        end
    end

    assign data_out   = data_reg;
    assign valid_out  = valid_reg;
    assign bubble_out = bubble_reg;

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall & ~flush),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a hold-mode and a legacy-mode instance share stimulus
// and are checked against a cycle-level reference model.
module tb_pipe_stage_reg;

    localparam int W  = 64;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          valid_in = 1'b0;

    logic [W-1:0]  h_data,  l_data;
    logic          h_valid, l_valid, h_bub, l_bub;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] h_scnt, h_fcnt, l_scnt, l_fcnt;
`endif

    // reference model state: index 0 = hold mode, 1 = legacy mode
    logic [W-1:0]  m_data [2];
    logic          m_valid[2];
    logic          m_bub  [2];
    int            m_scnt, m_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_stage_reg #(.WIDTH(W), .BUBBLE('0), .STALL_MODE(0), .BUBBLE_HI_W(32), .CNT_W(CW)) u_hold (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(h_data), .valid_out(h_valid), .bubble_out(h_bub)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(h_scnt), .flush_cnt(h_fcnt), .cnt_clr(cnt_clr)
`endif
    );

    pipe_stage_reg #(.WIDTH(W), .BUBBLE('0), .STALL_MODE(1), .BUBBLE_HI_W(32), .CNT_W(CW)) u_leg (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(l_data), .valid_out(l_valid), .bubble_out(l_bub)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(l_scnt), .flush_cnt(l_fcnt), .cnt_clr(cnt_clr)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".h_data"},  h_data,  m_data[0]);
        check({tag, ".h_valid"}, W'(h_valid), W'(m_valid[0]));
        check({tag, ".h_bub"},   W'(h_bub),   W'(m_bub[0]));
        check({tag, ".l_data"},  l_data,  m_data[1]);
        check({tag, ".l_valid"}, W'(l_valid), W'(m_valid[1]));
        check({tag, ".l_bub"},   W'(l_bub),   W'(m_bub[1]));
`ifdef PIPE_STAGE_PERF_EN
        check({tag, ".h_scnt"}, W'(h_scnt), W'(m_scnt));
        check({tag, ".h_fcnt"}, W'(h_fcnt), W'(m_fcnt));
        check({tag, ".l_scnt"}, W'(l_scnt), W'(m_scnt));
        check({tag, ".l_fcnt"}, W'(l_fcnt), W'(m_fcnt));
`endif
        $display("step %-10s stall=%0b flush=%0b din=%h vin=%0b -> hold %h/%0b/%0b legacy %h/%0b/%0b",
                 tag, stall, flush, data_in, valid_in, h_data, h_valid, h_bub, l_data, l_valid, l_bub);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
            m_bub[i]   = 1'b0;
        end
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    // One clock edge as the specification describes it, applied to the model
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                m_data[i] = '0; m_valid[i] = 1'b0; m_bub[i] = 1'b1;
            end else if (stall) begin
                if (i == 1) begin
                    m_data[i]  = m_data[i] % (64'd1 << 32);
                    m_valid[i] = 1'b0;
                    m_bub[i]   = 1'b1;
                end
            end else begin
                m_data[i] = data_in; m_valid[i] = valid_in; m_bub[i] = 1'b0;
            end
        end
        if (cnt_clr) begin
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (stall && !flush) m_scnt = (m_scnt + 1 > SAT) ? SAT : m_scnt + 1;
            if (flush)           m_fcnt = (m_fcnt + 1 > SAT) ? SAT : m_fcnt + 1;
        end
    endtask

    task automatic step(input string tag, input logic s, input logic f, input logic c,
                        input logic [W-1:0] d, input logic v);
        stall = s; flush = f; cnt_clr = c; data_in = d; valid_in = v;
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // 1: reset then load
        model_reset();
        data_in = 64'hDEAD_BEEF_DEAD_BEEF; valid_in = 1'b1;
        #3;
        check_all("reset");
        @(posedge clock); #1;
        check_all("in_reset");
        @(negedge clock); reset = 1'b1;
        step("load", 0, 0, 0, 64'h0000_0004_2402_0005, 1);

        // 2: hold stall for three cycles, then release
        step("clr", 0, 0, 1, 64'h0000_0004_2402_0005, 1);
        step("load_A", 0, 0, 0, 64'h0000_0008_8C43_0000, 1);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, {$urandom, $urandom}, 1);
        step("release", 0, 0, 0, 64'h0000_000C_0000_0001, 1);

        // 3: legacy stall, twice
        step("load_L", 0, 0, 0, 64'h1234_5678_0000_0010, 1);
        step("lstall1", 1, 0, 0, {$urandom, $urandom}, 1);
        check("legacy_val", l_data, 64'h0000_0000_0000_0010);
        step("lstall2", 1, 0, 0, {$urandom, $urandom}, 1);

        // 4: flush beats stall
        step("load_A2", 0, 0, 0, 64'h0000_0008_8C43_0000, 1);
        step("flush", 1, 1, 0, {$urandom, $urandom}, 1);

        // 5: asynchronous reset while stalled
        step("load_5", 0, 0, 0, 64'hAAAA_5555_1234_8765, 1);
        step("stall_5", 1, 0, 0, 64'h1111_2222_3333_4444, 1);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clock); reset = 1'b1;
        step("load_B", 0, 0, 0, 64'h0000_0010_0000_00BB, 1);

        // 6: counter saturation and clear-with-stall
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 0, {$urandom, $urandom}, 1);
        step("clr_stall", 1, 0, 1, {$urandom, $urandom}, 1);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 31) == 0), {$urandom, $urandom}, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
